// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if
//   Request/result bundle for the sequential binary-to-BCD converter.
//   master : drives start/bin, observes busy/done/digits/ovf (requester side)
//   slave  : the converter itself
//   start      - conversion request (honoured only when idle)
//   bin[13:0]  - unsigned value captured with an accepted start
//   busy       - conversion in progress
//   done       - one-cycle result strobe
//   dig3..dig0 - thousands/hundreds/tens/ones BCD digits
//   ovf        - out-of-range flag
interface bin_to_bcd_seq_if;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [3:0]  dig3;
    logic [3:0]  dig2;
    logic [3:0]  dig1;
    logic [3:0]  dig0;
    logic        ovf;

    modport master (output start, bin,
                    input  busy, done, dig3, dig2, dig1, dig0, ovf);
    modport slave  (input  start, bin,
                    output busy, done, dig3, dig2, dig1, dig0, ovf);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Sequential double-dabble converter: 14-bit unsigned binary to four BCD
//   digits, one iteration per clock. start accepted in IDLE at edge k gives
//   a done pulse in the cycle after edge k+15; digits update at that edge
//   and hold until the next result.
//
// Ports
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - bin_to_bcd_seq_if.slave (start, bin, busy, done, dig3..0, ovf)
//
// Configuration
//   BCD_OVF_EN defined   : inputs >9999 report dig3..0 = 4'hA and ovf=1.
//   BCD_OVF_EN undefined : the fifth-digit carry is dropped, the digits show
//                          bin mod 10000 and ovf is tied low.
module bin_to_bcd_seq (
    input  logic                   clk,
    input  logic                   rst_n,
    bin_to_bcd_seq_if.slave        bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [13:0] sr_q, sr_d;      // binary shift register
    logic [15:0] scr_q, scr_d;    // BCD scratch register
    logic [3:0]  cnt_q, cnt_d;    // iterations remaining
    logic [15:0] dig_q, dig_d;    // registered result digits
    logic        done_q, done_d;
    logic [15:0] adj;             // scratch after the add-3 correction

    // Each corrected nibble is at most 9+3=12, so nibbles never carry into
    // one another and the correction can be done per nibble in parallel.
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < 4; i++) begin
            if (scr_q[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = scr_q[i*4 +: 4] + 4'd3;
        end
    end

`ifdef BCD_OVF_EN
    // Sticky record of any bit shifted out of the thousands digit: once the
    // fifth digit is non-zero the final value is necessarily >9999.
    logic carry_q, carry_d;
    logic ovf_q, ovf_d;
`else
    logic unused_carry;
    assign unused_carry = adj[15];
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        done_d  = 1'b0;
`ifdef BCD_OVF_EN
        carry_d = carry_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sr_d    = bus.bin;
                    scr_d   = 16'd0;
                    cnt_d   = 4'd14;
`ifdef BCD_OVF_EN
                    carry_d = 1'b0;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = {adj[14:0], sr_q[13]};
                sr_d  = {sr_q[12:0], 1'b0};
                cnt_d = cnt_q - 4'd1;
`ifdef BCD_OVF_EN
                carry_d = carry_q | adj[15];
`endif
                if (cnt_q == 4'd1)
                    state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef BCD_OVF_EN
                if (carry_q) begin
                    dig_d = 16'hAAAA;
                    ovf_d = 1'b1;
                end else begin
                    dig_d = scr_q;
                    ovf_d = 1'b0;
                end
`else
                dig_d = scr_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            done_q  <= done_d;
        end
    end

`ifdef BCD_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end
    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.dig3 = dig_q[15:12];
    assign bus.dig2 = dig_q[11:8];
    assign bus.dig1 = dig_q[7:4];
    assign bus.dig0 = dig_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq
//   Scoreboard bench for bin_to_bcd_seq. Each accepted start pushes the
//   expected digits/ovf and the start cycle; a negedge monitor pops on done
//   and checks value and latency. Honours BCD_OVF_EN like the design.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_seq_if b_if ();

    bin_to_bcd_seq u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    typedef struct {
        logic [15:0] dig;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int v, input int c);
        exp_t e;
        int   m;
        e.cyc = c;
        e.ovf = 1'b0;
`ifdef BCD_OVF_EN
        if (v > 9999) begin
            e.dig = 16'hAAAA;
            e.ovf = 1'b1;
            return e;
        end
`endif
        m = v % 10000;
        e.dig = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
        return e;
    endfunction

    // Result monitor: every done must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && b_if.done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("digits", int'({b_if.dig3, b_if.dig2, b_if.dig1, b_if.dig0}), int'(e.dig));
                chk("ovf", int'(b_if.ovf), int'(e.ovf));
                chk("latency", cyc - e.cyc, 15);
                chk("busy_after_done", int'(b_if.busy), 0);
            end
        end
    end

    // Called at a negedge; start is sampled at the following rising edge.
    task automatic conv(input int v);
        int n = 0;
        while (b_if.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (b_if.busy) chk("idle_wait", 1, 0);
        b_if.start = 1'b1;
        b_if.bin   = 14'(v);
        @(posedge clk);
        #1;
        sb.push_back(model(v, cyc));
        b_if.start = 1'b0;
        chk("busy_on_start", int'(b_if.busy), 1);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_if.done && n < 40);
        if (!b_if.done) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_digits"}, int'({b_if.dig3, b_if.dig2, b_if.dig1, b_if.dig0}), 0);
        chk({tag, "_busy"}, int'(b_if.busy), 0);
        chk({tag, "_done"}, int'(b_if.done), 0);
        chk({tag, "_ovf"}, int'(b_if.ovf), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int vals[8] = '{9, 10, 99, 100, 999, 1000, 5000, 8191};

        rst_n      = 1'b0;
        b_if.start = 1'b0;
        b_if.bin   = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");

        // Start offered at the very first edge after reset release.
        rst_n = 1'b1;
        conv(0);
        wait_done();

        // Back-to-back: next start issued in the cycle done is seen.
        conv(9999);
        wait_done();
        conv(1234);
        wait_done();

        conv(10000);
        wait_done();
        conv(16383);
        wait_done();

        foreach (vals[i]) begin
            conv(vals[i]);
            wait_done();
        end
        for (int i = 0; i < 4; i++) begin
            conv(int'($urandom_range(0, 16383)));
            wait_done();
        end

        // Re-pulse start with a different bin at edges k+5 and k+15 (DONE).
        conv(2468);
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
            b_if.start = (j == 5 || j == 15);
            b_if.bin   = 14'(7777 + j);
        end
        @(negedge clk);
        b_if.start = 1'b0;
        repeat (25) @(negedge clk);

        // Reset mid-conversion aborts without a done pulse.
        conv(4321);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        conv(4321);
        wait_done();

        repeat (20) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
